// File: rtl/z88_mem_pkg.sv
// Shared definitions for the slot-0 memory path: address widths, decode
// constants, the arbiter state encoding and two small arithmetic helpers.
package z88_mem_pkg;

    // CPU/video side address is bank[7:0] + offset[13:0]; the slot-0 bus
    // itself only carries the low 19 bits.
    localparam int CPU_AW = 22;
    localparam int MEM_AW = 19;

    // Value of a[21:19] that selects each slot-0 device.
    localparam logic [2:0] SLOT0_ROM = 3'b000;
    localparam logic [2:0] SLOT0_RAM = 3'b001;

    // Read result for anything that does not hit a device.
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // Bus sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Number of ACCESS cycles for the direction being started.
    function automatic logic [3:0] access_cycles(
        input logic       we,
        input logic [3:0] rd_cycles,
        input logic [3:0] wr_cycles
    );
        return we ? wr_cycles : rd_cycles;
    endfunction

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/slot0_decode.sv
// Slot-0 address decoder: splits a 22-bit CPU-space address into ROM/RAM
// selects and the 19-bit address that goes onto the slot-0 pins. Purely
// combinational so it can also be used by debug logic next to the blink.
module slot0_decode
    import z88_mem_pkg::*;
(
    input  logic [CPU_AW-1:0] i_addr,
    output logic              o_rom_sel,
    output logic              o_ram_sel,
    output logic [MEM_AW-1:0] o_mem_a
);

    logic [CPU_AW-MEM_AW-1:0] w_slot_bits;

    assign w_slot_bits = i_addr[CPU_AW-1:MEM_AW];

    // The selects are mutually exclusive by construction: one 3-bit field
    // can only match one constant.
    assign o_rom_sel = (w_slot_bits == SLOT0_ROM);
    assign o_ram_sel = (w_slot_bits == SLOT0_RAM);
    assign o_mem_a   = i_addr[MEM_AW-1:0];

endmodule

// File: rtl/slot0_mem_arbiter.sv
// Slot-0 memory arbiter. Shares the internal ROM/RAM bus between the Z80
// memory path and the screen fetch path, sequences CE/OE/WE with
// programmable wait states and returns registered read data together with
// a one-cycle acknowledge. Every bus strobe and handshake output comes
// straight from a flop so the pins are glitch-free.
module slot0_mem_arbiter
    import z88_mem_pkg::*;
#(
    parameter int RD_WAIT      = 2,
    parameter int WR_WAIT      = 2,
    parameter int VID_MAX_WAIT = 8
) (
    input  logic              mck,
    input  logic              rin_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_a,
    input  logic [7:0]        cpu_wd,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rd,
    input  logic              vid_req,
    input  logic [CPU_AW-1:0] vid_a,
    output logic              vid_ack,
    output logic [7:0]        vid_rd,
    output logic [MEM_AW-1:0] mem_a,
    output logic [7:0]        mem_wd,
    output logic              ram_ce_n,
    output logic              rom_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    input  logic [7:0]        ram_do,
    input  logic [7:0]        rom_do
);

    localparam logic [3:0] RD_CYCLES     = 4'(RD_WAIT);
    localparam logic [3:0] WR_CYCLES     = 4'(WR_WAIT);
    localparam logic [7:0] VID_AGE_LIMIT = 8'(VID_MAX_WAIT);

    // Sequencer context latched at grant time.
    arb_state_t        r_state;
    logic              r_owner_vid;
    logic              r_we;
    logic              r_rom_sel;
    logic              r_ram_sel;
    logic [3:0]        r_cnt;
    logic [7:0]        r_vid_age;

    // Registered outputs.
    logic [MEM_AW-1:0] r_mem_a;
    logic [7:0]        r_mem_wd;
    logic              r_ram_ce_n;
    logic              r_rom_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_cpu_ack;
    logic              r_vid_ack;
    logic [7:0]        r_cpu_rd;
    logic [7:0]        r_vid_rd;

    // Grant-side combinational signals.
    logic              w_any_req;
    logic              w_vid_win;
    logic [CPU_AW-1:0] w_grant_a;
    logic              w_grant_we;
    logic              w_rom_sel;
    logic              w_ram_sel;
    logic [MEM_AW-1:0] w_mem_a;
    logic              w_mapped;
    logic [7:0]        w_read_data;

    assign w_any_req = cpu_req | vid_req;

    // Video takes the bus when the CPU is quiet, or once it has been
    // passed over often enough that the screen fetch would starve.
    assign w_vid_win  = vid_req & (~cpu_req | (r_vid_age >= VID_AGE_LIMIT));
    assign w_grant_a  = w_vid_win ? vid_a : cpu_a;
    assign w_grant_we = w_vid_win ? 1'b0 : cpu_we;

    slot0_decode u_decode (
        .i_addr    (w_grant_a),
        .o_rom_sel (w_rom_sel),
        .o_ram_sel (w_ram_sel),
        .o_mem_a   (w_mem_a)
    );

    // ROM writes are not a bus cycle at all: they are completed like an
    // unmapped access so no strobe ever reaches the ROM.
    assign w_mapped = w_ram_sel | (w_rom_sel & ~w_grant_we);

    // Data source for the capture at the end of ACCESS.
    assign w_read_data = r_rom_sel ? rom_do : ram_do;

    // Bus sequencer: arbitration, strobe generation, wait counting and the
    // ack/read-data registers, all as one registered state machine.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_state     <= ST_IDLE;
            r_owner_vid <= 1'b0;
            r_we        <= 1'b0;
            r_rom_sel   <= 1'b0;
            r_ram_sel   <= 1'b0;
            r_cnt       <= 4'd0;
            r_mem_a     <= '0;
            r_mem_wd    <= 8'h00;
            r_ram_ce_n  <= 1'b1;
            r_rom_ce_n  <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rd    <= OPEN_BUS;
            r_vid_rd    <= OPEN_BUS;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_vid <= w_vid_win;
                        r_we        <= w_grant_we;
                        r_mem_a     <= w_mem_a;
                        r_cnt       <= access_cycles(w_grant_we, RD_CYCLES, WR_CYCLES);
                        // Video never writes, so keep the last CPU data on
                        // the bus rather than toggling it for nothing.
                        if (!w_vid_win) begin
                            r_mem_wd <= cpu_wd;
                        end
                        if (w_mapped) begin
                            // Address/data setup cycle: chip selected, OE
                            // for reads, WE still high.
                            r_rom_sel  <= w_rom_sel;
                            r_ram_sel  <= w_ram_sel;
                            r_rom_ce_n <= ~w_rom_sel;
                            r_ram_ce_n <= ~w_ram_sel;
                            r_oe_n     <= w_grant_we;
                            r_state    <= ST_SETUP;
                        end else begin
                            // Unmapped or ROM write: finish immediately,
                            // reads return the open-bus value.
                            r_rom_sel <= 1'b0;
                            r_ram_sel <= 1'b0;
                            if (w_vid_win) begin
                                r_vid_ack <= 1'b1;
                                r_vid_rd  <= OPEN_BUS;
                            end else begin
                                r_cpu_ack <= 1'b1;
                                if (!cpu_we) begin
                                    r_cpu_rd <= OPEN_BUS;
                                end
                            end
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_SETUP: begin
                    // WE drops for the whole ACCESS window on writes.
                    r_we_n  <= ~r_we;
                    r_state <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (r_cnt <= 4'd1) begin
                        // Last access edge: release every strobe, capture
                        // read data and acknowledge the owner. Address and
                        // write data stay put as hold time.
                        r_rom_ce_n <= 1'b1;
                        r_ram_ce_n <= 1'b1;
                        r_oe_n     <= 1'b1;
                        r_we_n     <= 1'b1;
                        if (r_owner_vid) begin
                            r_vid_ack <= 1'b1;
                            r_vid_rd  <= w_read_data;
                        end else begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) begin
                                r_cpu_rd <= w_read_data;
                            end
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_DONE: begin
                    r_cpu_ack <= 1'b0;
                    r_vid_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Video starvation counter: ages while the CPU holds or wins the bus
    // with video waiting, resets as soon as video is served or withdraws.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            r_vid_age <= 8'd0;
        end else if (!vid_req) begin
            r_vid_age <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_vid_win) begin
                r_vid_age <= 8'd0;
            end else begin
                r_vid_age <= sat_inc8(r_vid_age);
            end
        end else if (!r_owner_vid) begin
            r_vid_age <= sat_inc8(r_vid_age);
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_wd   = r_mem_wd;
    assign ram_ce_n = r_ram_ce_n;
    assign rom_ce_n = r_rom_ce_n;
    assign mem_oe_n = r_oe_n;
    assign mem_we_n = r_we_n;
    assign cpu_ack  = r_cpu_ack;
    assign cpu_rd   = r_cpu_rd;
    assign vid_ack  = r_vid_ack;
    assign vid_rd   = r_vid_rd;

endmodule

// File: tb/tb_slot0_mem_arbiter.sv
// Directed bench for slot0_mem_arbiter with behavioural ROM/RAM models and
// an ordered scoreboard of expected acknowledges.
module tb_slot0_mem_arbiter;

    localparam int RD_WAIT      = 2;
    localparam int WR_WAIT      = 2;
    localparam int VID_MAX_WAIT = 8;

    logic        mck;
    logic        rin_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_a;
    logic [7:0]  cpu_wd;
    logic        cpu_ack;
    logic [7:0]  cpu_rd;
    logic        vid_req;
    logic [21:0] vid_a;
    logic        vid_ack;
    logic [7:0]  vid_rd;
    logic [18:0] mem_a;
    logic [7:0]  mem_wd;
    logic        ram_ce_n;
    logic        rom_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [7:0]  ram_do;
    logic [7:0]  rom_do;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] last_cpu_rd = 8'hFF;

    typedef struct {
        bit         vid;
        logic [7:0] data;
        string      tag;
    } exp_t;
    exp_t sb[$];

    logic [21:0] clist [0:4] = '{22'h100000, 22'h200001, 22'h3FFFFF, 22'h180000, 22'h000155};

    slot0_mem_arbiter #(
        .RD_WAIT      (RD_WAIT),
        .WR_WAIT      (WR_WAIT),
        .VID_MAX_WAIT (VID_MAX_WAIT)
    ) dut (
        .mck      (mck),
        .rin_n    (rin_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_a    (cpu_a),
        .cpu_wd   (cpu_wd),
        .cpu_ack  (cpu_ack),
        .cpu_rd   (cpu_rd),
        .vid_req  (vid_req),
        .vid_a    (vid_a),
        .vid_ack  (vid_ack),
        .vid_rd   (vid_rd),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .ram_ce_n (ram_ce_n),
        .rom_ce_n (rom_ce_n),
        .mem_oe_n (mem_oe_n),
        .mem_we_n (mem_we_n),
        .ram_do   (ram_do),
        .rom_do   (rom_do)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    // Memory models: ROM content is an address hash, RAM is an init hash
    // overlaid with whatever has been written. Undriven reads give 00 so a
    // read without proper strobes cannot return the right value by luck.
    function automatic logic [7:0] rom_val(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    function automatic logic [7:0] ram_init(input logic [18:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    bit         ram_wr  [0:1023];
    logic [7:0] ram_dat [0:1023];

    always @(posedge mck) begin
        if (!ram_ce_n && !mem_we_n) begin
            ram_dat[mem_a[9:0]] <= mem_wd;
            ram_wr[mem_a[9:0]]  <= 1'b1;
        end
    end

    assign rom_do = (!rom_ce_n && !mem_oe_n) ? rom_val(mem_a) : 8'h00;
    assign ram_do = (!ram_ce_n && !mem_oe_n) ?
                    (ram_wr[mem_a[9:0]] ? ram_dat[mem_a[9:0]] : ram_init(mem_a)) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Per-cycle bus invariants and scoreboard pop on every acknowledge.
    always @(negedge mck) begin
        if (rin_n) begin
            check("ce_excl", 32'(ram_ce_n | rom_ce_n), 32'd1);
            check("we_oe", 32'(!mem_we_n && !mem_oe_n), 32'd0);
            check("ack_excl", 32'(cpu_ack && vid_ack), 32'd0);
            if (cpu_ack || vid_ack) begin
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_src"}, 32'(vid_ack), 32'(e.vid));
                    check({e.tag, "_rd"}, 32'(e.vid ? vid_rd : cpu_rd), 32'(e.data));
                    $display("ack %s: src=%s rd=%02h", e.tag, vid_ack ? "vid" : "cpu",
                             vid_ack ? vid_rd : cpu_rd);
                end
            end
        end
    end

    // One complete CPU transaction started from IDLE, with strobe census.
    task automatic cpu_access(input string tag, input logic [21:0] a, input logic we,
                              input logic [7:0] wd, input logic [7:0] rd_exp,
                              input int lat_exp, input int rom_ce_exp, input int ram_ce_exp,
                              input int oe_exp, input int we_exp);
        exp_t        e;
        int          lat;
        int          n_rom;
        int          n_ram;
        int          n_oe;
        int          n_we;
        logic [18:0] a_seen;
        logic [7:0]  wd_seen;
        e.vid  = 1'b0;
        e.tag  = tag;
        e.data = we ? last_cpu_rd : rd_exp;
        if (!we) last_cpu_rd = rd_exp;
        sb.push_back(e);
        @(posedge mck); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_wd = wd;
        lat = -1; n_rom = 0; n_ram = 0; n_oe = 0; n_we = 0; a_seen = '0; wd_seen = 8'h00;
        for (int n = 0; n < 40; n++) begin
            @(negedge mck);
            if (!rom_ce_n) n_rom++;
            if (!ram_ce_n) n_ram++;
            if (!mem_oe_n) n_oe++;
            if (!rom_ce_n || !ram_ce_n) a_seen = mem_a;
            if (!mem_we_n) begin
                n_we++;
                wd_seen = mem_wd;
            end
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_rom_ce"}, 32'(n_rom), 32'(rom_ce_exp));
        check({tag, "_ram_ce"}, 32'(n_ram), 32'(ram_ce_exp));
        check({tag, "_oe"}, 32'(n_oe), 32'(oe_exp));
        check({tag, "_we"}, 32'(n_we), 32'(we_exp));
        if (rom_ce_exp + ram_ce_exp > 0) check({tag, "_mem_a"}, 32'(a_seen), 32'(a[18:0]));
        if (we_exp > 0) check({tag, "_wd"}, 32'(wd_seen), 32'(wd));
        @(posedge mck); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   hit;
        bit   cdone;
        bit   vdone;
        int   ci;

        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_wd = 8'h00;
        vid_req = 1'b0; vid_a = '0;
        rin_n = 1'b1;
        #2 rin_n = 1'b0;
        #10;

        // Reset state.
        check("rst_ram_ce_n", 32'(ram_ce_n), 32'd1);
        check("rst_rom_ce_n", 32'(rom_ce_n), 32'd1);
        check("rst_oe_n", 32'(mem_oe_n), 32'd1);
        check("rst_we_n", 32'(mem_we_n), 32'd1);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_cpu_rd", 32'(cpu_rd), 32'hFF);
        check("rst_vid_rd", 32'(vid_rd), 32'hFF);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_wd", 32'(mem_wd), 32'd0);
        @(negedge mck); rin_n = 1'b1;

        // Reset in the middle of a RAM write.
        @(posedge mck); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 22'h080010; cpu_wd = 8'h3C;
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge mck);
            if (!mem_we_n) begin
                hit = 1'b1;
                break;
            end
        end
        check("midwr_in_access", 32'(hit), 32'd1);
        #2 rin_n = 1'b0;
        #1;
        check("midwr_we_n", 32'(mem_we_n), 32'd1);
        check("midwr_ram_ce_n", 32'(ram_ce_n), 32'd1);
        check("midwr_cpu_ack", 32'(cpu_ack), 32'd0);
        check("midwr_cpu_rd", 32'(cpu_rd), 32'hFF);
        check("midwr_mem_wd", 32'(mem_wd), 32'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge mck);
            check("midwr_hold_ack", 32'(cpu_ack), 32'd0);
        end
        rin_n = 1'b1;
        $display("reset mid-write done");

        // Directed single CPU accesses.
        cpu_access("rom_rd", 22'h000123, 1'b0, 8'h00, 8'h5A, 2 + RD_WAIT, 1 + RD_WAIT, 0, 1 + RD_WAIT, 0);
        cpu_access("ram_wr", 22'h080040, 1'b1, 8'hA5, 8'h00, 2 + WR_WAIT, 0, 1 + WR_WAIT, 0, WR_WAIT);
        cpu_access("ram_rdback", 22'h080040, 1'b0, 8'h00, 8'hA5, 2 + RD_WAIT, 0, 1 + RD_WAIT, 1 + RD_WAIT, 0);
        cpu_access("unmapped_rd", 22'h100000, 1'b0, 8'h00, 8'hFF, 1, 0, 0, 0, 0);
        cpu_access("ram_rd41", 22'h080041, 1'b0, 8'h00, ram_init(19'h00041), 2 + RD_WAIT, 0, 1 + RD_WAIT, 1 + RD_WAIT, 0);
        cpu_access("rom_wr", 22'h000010, 1'b1, 8'h99, 8'h00, 1, 0, 0, 0, 0);

        // Simultaneous requests with a fresh video age: CPU first.
        e.vid = 1'b0; e.data = rom_val(19'h00200); e.tag = "sim_cpu"; sb.push_back(e);
        last_cpu_rd = e.data;
        e.vid = 1'b1; e.data = ram_init(19'h00042); e.tag = "sim_vid"; sb.push_back(e);
        @(posedge mck); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 22'h000200;
        vid_req = 1'b1; vid_a = 22'h080042;
        cdone = 1'b0; vdone = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge mck);
            if (cpu_ack) begin cpu_req = 1'b0; cdone = 1'b1; end
            if (vid_ack) begin vid_req = 1'b0; vdone = 1'b1; end
            if (cdone && vdone) break;
        end
        check("sim_both_done", 32'({cdone, vdone}), 32'b11);
        cpu_req = 1'b0; vid_req = 1'b0;

        // Video read data must hold across unrelated CPU traffic.
        cpu_access("rom_rd300", 22'h000300, 1'b0, 8'h00, rom_val(19'h00300), 2 + RD_WAIT, 1 + RD_WAIT, 0, 1 + RD_WAIT, 0);
        check("vid_rd_hold", 32'(vid_rd), 32'(ram_init(19'h00042)));

        // Contention: CPU re-requests every IDLE, video waits until aged.
        for (int i = 0; i < 4; i++) begin
            e.vid = 1'b0; e.data = 8'hFF; e.tag = $sformatf("cont_cpu%0d", i); sb.push_back(e);
        end
        e.vid = 1'b1; e.data = ram_init(19'h00041); e.tag = "cont_vid"; sb.push_back(e);
        e.vid = 1'b0; e.data = rom_val(19'h00155); e.tag = "cont_cpu4"; sb.push_back(e);
        last_cpu_rd = e.data;
        @(posedge mck); #1;
        ci = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = clist[0];
        vid_req = 1'b1; vid_a = 22'h080041;
        cdone = 1'b0; vdone = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(negedge mck);
            if (cpu_ack) begin
                ci++;
                if (ci < 5) cpu_a = clist[ci];
                else begin
                    cpu_req = 1'b0;
                    cdone = 1'b1;
                end
            end
            if (vid_ack) begin
                vid_req = 1'b0;
                vdone = 1'b1;
            end
            if (cdone && vdone) break;
        end
        check("cont_both_done", 32'({cdone, vdone}), 32'b11);
        cpu_req = 1'b0; vid_req = 1'b0;

        repeat (3) @(posedge mck);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
